// File: rtl/riscv_pkg.sv
// Shared types and constants for the issue stage: micro-op payload layout,
// physical tag width and the writeback tag-match helper.
package riscv_pkg;

  localparam int NUM_P_REGS        = 64;
  localparam int PTAG_W            = $clog2(NUM_P_REGS);
  localparam int WORD_SIZE         = 32;
  localparam int ALU_OP_SIZE       = 4;
  localparam int CONTR_SIG_SIZE    = 5;
  localparam int CONTR_VALID_INDEX = 0;

  typedef struct packed {
    logic [ALU_OP_SIZE-1:0]    alu_op;
    logic [WORD_SIZE-1:0]      imm;
    logic [CONTR_SIG_SIZE-1:0] contr;
    logic [PTAG_W-1:0]         p_rd;
    logic [PTAG_W-1:0]         p_rs1;
    logic [PTAG_W-1:0]         p_rs2;
  } iq_uop_t;

  function automatic logic tag_hit(input logic [PTAG_W-1:0] tag,
                                   input logic v0, input logic [PTAG_W-1:0] t0,
                                   input logic v1, input logic [PTAG_W-1:0] t1);
    return (v0 && (t0 == tag)) || (v1 && (t1 == tag));
  endfunction

endpackage

// File: rtl/iq_pick2.sv
// Two-way priority picker: returns the lowest and second-lowest set bit of a
// request vector, each with a valid flag.
module iq_pick2 #(
  parameter  int NUM_ENTRIES = 8,
  localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic [NUM_ENTRIES-1:0] req,
  output logic [IDX_W-1:0]       idx0,
  output logic                   vld0,
  output logic [IDX_W-1:0]       idx1,
  output logic                   vld1
);

  always_comb begin
    idx0 = '0;
    idx1 = '0;
    vld0 = 1'b0;
    vld1 = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (req[i]) begin
        if (!vld0) begin
          vld0 = 1'b1;
          idx0 = IDX_W'(i);
        end else if (!vld1) begin
          vld1 = 1'b1;
          idx1 = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// Dual-issue oldest-first scheduler over a collapsing queue (entry 0 oldest).
// Define IQ_WAKEUP_BYPASS_EN to let same-cycle writeback tags feed selection.
module issue_scheduler
  import riscv_pkg::*;
#(
  parameter  int NUM_ENTRIES = 8,
  localparam int IDX_W       = $clog2(NUM_ENTRIES),
  localparam int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              disp0_valid_i,
  input  iq_uop_t           disp0_uop_i,
  input  logic              disp0_rs1_rdy_i,
  input  logic              disp0_rs2_rdy_i,
  input  logic              disp1_valid_i,
  input  iq_uop_t           disp1_uop_i,
  input  logic              disp1_rs1_rdy_i,
  input  logic              disp1_rs2_rdy_i,
  input  logic              wb0_valid_i,
  input  logic [PTAG_W-1:0] wb0_tag_i,
  input  logic              wb1_valid_i,
  input  logic [PTAG_W-1:0] wb1_tag_i,
  input  logic              iss_stall_i,
  output logic              iq_full_o,
  output logic              iss0_valid_o,
  output iq_uop_t           iss0_uop_o,
  output logic              iss1_valid_o,
  output iq_uop_t           iss1_uop_o,
  output logic [CNT_W-1:0]  iq_count_o
);

  // Queue state (p0) and issue output registers (p1)
  logic [NUM_ENTRIES-1:0] ent_vld_p0, ent_rs1_p0, ent_rs2_p0;
  iq_uop_t                ent_uop_p0 [NUM_ENTRIES];
  logic [CNT_W-1:0]       cnt_p0;
  logic                   full_p0;
  logic                   iss0_vld_p1, iss1_vld_p1;
  iq_uop_t                iss0_uop_p1, iss1_uop_p1;

  logic [NUM_ENTRIES-1:0] vld_nxt, rs1_nxt, rs2_nxt;
  iq_uop_t                uop_nxt [NUM_ENTRIES];
  logic [CNT_W-1:0]       cnt_nxt;
  logic [NUM_ENTRIES-1:0] wake1, wake2, rdy_vec, take_vec;
  logic [IDX_W-1:0]       sel_idx0, sel_idx1, wp;
  logic                   sel_vld0, sel_vld1, take0, take1;
  logic                   alloc0, alloc1;
  logic                   d0_rs1, d0_rs2, d1_rs1, d1_rs2;

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      wake1[i] = tag_hit(ent_uop_p0[i].p_rs1, wb0_valid_i, wb0_tag_i, wb1_valid_i, wb1_tag_i);
      wake2[i] = tag_hit(ent_uop_p0[i].p_rs2, wb0_valid_i, wb0_tag_i, wb1_valid_i, wb1_tag_i);
    end
  end

`ifdef IQ_WAKEUP_BYPASS_EN
  assign rdy_vec = ent_vld_p0 & (ent_rs1_p0 | wake1) & (ent_rs2_p0 | wake2);
`else
  assign rdy_vec = ent_vld_p0 & ent_rs1_p0 & ent_rs2_p0;
`endif

  iq_pick2 #(.NUM_ENTRIES(NUM_ENTRIES)) u_pick (
    .req  (rdy_vec),
    .idx0 (sel_idx0),
    .vld0 (sel_vld0),
    .idx1 (sel_idx1),
    .vld1 (sel_vld1)
  );

  assign take0 = sel_vld0 && !iss_stall_i;
  assign take1 = sel_vld1 && !iss_stall_i;

  always_comb begin
    take_vec = '0;
    if (take0) take_vec[sel_idx0] = 1'b1;
    if (take1) take_vec[sel_idx1] = 1'b1;
  end

  // Free-slot check uses the registered count, so slots freed this cycle wait a cycle
  assign alloc0 = disp0_valid_i && !full_p0 && disp0_uop_i.contr[CONTR_VALID_INDEX];
  assign alloc1 = disp1_valid_i && !full_p0 && disp1_uop_i.contr[CONTR_VALID_INDEX];

  assign d0_rs1 = disp0_rs1_rdy_i | tag_hit(disp0_uop_i.p_rs1, wb0_valid_i, wb0_tag_i, wb1_valid_i, wb1_tag_i);
  assign d0_rs2 = disp0_rs2_rdy_i | tag_hit(disp0_uop_i.p_rs2, wb0_valid_i, wb0_tag_i, wb1_valid_i, wb1_tag_i);
  assign d1_rs1 = disp1_rs1_rdy_i | tag_hit(disp1_uop_i.p_rs1, wb0_valid_i, wb0_tag_i, wb1_valid_i, wb1_tag_i);
  assign d1_rs2 = disp1_rs2_rdy_i | tag_hit(disp1_uop_i.p_rs2, wb0_valid_i, wb0_tag_i, wb1_valid_i, wb1_tag_i);

  always_comb begin
    vld_nxt = '0;
    rs1_nxt = '0;
    rs2_nxt = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) uop_nxt[i] = '0;
    wp = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (ent_vld_p0[i] && !take_vec[i]) begin
        vld_nxt[wp] = 1'b1;
        rs1_nxt[wp] = ent_rs1_p0[i] | wake1[i];
        rs2_nxt[wp] = ent_rs2_p0[i] | wake2[i];
        uop_nxt[wp] = ent_uop_p0[i];
        wp          = wp + IDX_W'(1);
      end
    end
    if (alloc0) begin
      vld_nxt[wp] = 1'b1;
      rs1_nxt[wp] = d0_rs1;
      rs2_nxt[wp] = d0_rs2;
      uop_nxt[wp] = disp0_uop_i;
      wp          = wp + IDX_W'(1);
    end
    if (alloc1) begin
      vld_nxt[wp] = 1'b1;
      rs1_nxt[wp] = d1_rs1;
      rs2_nxt[wp] = d1_rs2;
      uop_nxt[wp] = disp1_uop_i;
    end
  end

  assign cnt_nxt = cnt_p0 - CNT_W'(take0) - CNT_W'(take1) + CNT_W'(alloc0) + CNT_W'(alloc1);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ent_vld_p0  <= '0;
      ent_rs1_p0  <= '0;
      ent_rs2_p0  <= '0;
      cnt_p0      <= '0;
      full_p0     <= 1'b0;
      iss0_vld_p1 <= 1'b0;
      iss1_vld_p1 <= 1'b0;
      iss0_uop_p1 <= '0;
      iss1_uop_p1 <= '0;
    end else begin
      ent_vld_p0 <= vld_nxt;
      ent_rs1_p0 <= rs1_nxt;
      ent_rs2_p0 <= rs2_nxt;
      cnt_p0     <= cnt_nxt;
      full_p0    <= (cnt_nxt >= CNT_W'(NUM_ENTRIES - 1));
      if (!iss_stall_i) begin
        iss0_vld_p1 <= sel_vld0;
        iss1_vld_p1 <= sel_vld1;
        iss0_uop_p1 <= sel_vld0 ? ent_uop_p0[sel_idx0] : '0;
        iss1_uop_p1 <= sel_vld1 ? ent_uop_p0[sel_idx1] : '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_ENTRIES; i++) ent_uop_p0[i] <= uop_nxt[i];
  end

  assign iq_full_o    = full_p0;
  assign iq_count_o   = cnt_p0;
  assign iss0_valid_o = iss0_vld_p1;
  assign iss1_valid_o = iss1_vld_p1;
  assign iss0_uop_o   = iss0_uop_p1;
  assign iss1_uop_o   = iss1_uop_p1;

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed vector table, hand-written full/stall
// sequences, then random traffic against a queue-based reference model.
module tb_issue_scheduler;
  import riscv_pkg::*;

  localparam int N = 8;
`ifdef IQ_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic d0v, d0r1, d0r2, d1v, d1r1, d1r2, wb0v, wb1v, stall;
  iq_uop_t d0u, d1u;
  logic [PTAG_W-1:0] wb0t, wb1t;
  logic full, v0, v1;
  iq_uop_t u0, u1;
  logic [3:0] cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  issue_scheduler #(.NUM_ENTRIES(N)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .disp0_valid_i(d0v), .disp0_uop_i(d0u), .disp0_rs1_rdy_i(d0r1), .disp0_rs2_rdy_i(d0r2),
    .disp1_valid_i(d1v), .disp1_uop_i(d1u), .disp1_rs1_rdy_i(d1r1), .disp1_rs2_rdy_i(d1r2),
    .wb0_valid_i(wb0v), .wb0_tag_i(wb0t), .wb1_valid_i(wb1v), .wb1_tag_i(wb1t),
    .iss_stall_i(stall), .iq_full_o(full),
    .iss0_valid_o(v0), .iss0_uop_o(u0), .iss1_valid_o(v1), .iss1_uop_o(u1),
    .iq_count_o(cnt)
  );

  // Reference model: ordered list of waiting uops plus expected issue registers
  typedef struct { iq_uop_t u; logic r1; logic r2; } ment_t;
  ment_t   mq[$];
  logic    m_v0, m_v1, m_full;
  iq_uop_t m_u0, m_u1;

  function automatic logic hit(input logic [PTAG_W-1:0] t);
    return (wb0v && wb0t == t) || (wb1v && wb1t == t);
  endfunction

  function automatic logic m_ready(input ment_t e);
    return (e.r1 || (BYP && hit(e.u.p_rs1))) && (e.r2 || (BYP && hit(e.u.p_rs2)));
  endfunction

  task automatic model_step();
    int f0, f1;
    logic was_full;
    ment_t e;
    if (!rst_n) begin
      mq.delete();
      m_v0 = 1'b0; m_v1 = 1'b0; m_u0 = '0; m_u1 = '0; m_full = 1'b0;
      return;
    end
    was_full = m_full;
    if (!stall) begin
      f0 = -1; f1 = -1;
      for (int i = 0; i < mq.size(); i++)
        if (m_ready(mq[i])) begin
          if (f0 < 0) f0 = i;
          else if (f1 < 0) f1 = i;
        end
      m_v0 = (f0 >= 0); m_u0 = (f0 >= 0) ? mq[f0].u : '0;
      m_v1 = (f1 >= 0); m_u1 = (f1 >= 0) ? mq[f1].u : '0;
      if (f1 >= 0) mq.delete(f1);
      if (f0 >= 0) mq.delete(f0);
    end
    for (int i = 0; i < mq.size(); i++) begin
      e = mq[i];
      e.r1 = e.r1 | hit(e.u.p_rs1);
      e.r2 = e.r2 | hit(e.u.p_rs2);
      mq[i] = e;
    end
    if (!was_full) begin
      if (d0v && d0u.contr[0]) begin
        e.u = d0u; e.r1 = d0r1 | hit(d0u.p_rs1); e.r2 = d0r2 | hit(d0u.p_rs2);
        mq.push_back(e);
      end
      if (d1v && d1u.contr[0]) begin
        e.u = d1u; e.r1 = d1r1 | hit(d1u.p_rs1); e.r2 = d1r2 | hit(d1u.p_rs2);
        mq.push_back(e);
      end
    end
    m_full = (mq.size() >= N - 1);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    rst_n = 1'b1; d0v = 1'b0; d1v = 1'b0; d0u = '0; d1u = '0;
    d0r1 = 1'b0; d0r2 = 1'b0; d1r1 = 1'b0; d1r2 = 1'b0;
    wb0v = 1'b0; wb1v = 1'b0; wb0t = '0; wb1t = '0; stall = 1'b0;
  endtask

  function automatic iq_uop_t mk(input logic [5:0] rd, input logic [5:0] rs1,
                                 input logic [5:0] rs2, input logic cv);
    iq_uop_t u;
    u.alu_op = rd[3:0];
    u.imm    = 32'h1000 + 32'(rd);
    u.contr  = {4'b0010, cv};
    u.p_rd   = rd;
    u.p_rs1  = rs1;
    u.p_rs2  = rs2;
    return u;
  endfunction

  function automatic iq_uop_t rnd_uop();
    iq_uop_t u;
    u.alu_op   = 4'($urandom);
    u.imm      = $urandom;
    u.contr    = 5'($urandom);
    u.contr[0] = ($urandom_range(0, 9) != 0);
    u.p_rd     = 6'($urandom);
    u.p_rs1    = 6'($urandom_range(0, 7));
    u.p_rs2    = 6'($urandom_range(0, 7));
    return u;
  endfunction

  typedef struct {
    int d0v, d0c, d0rd, d0rs1, d0rs2, d0r1, d0r2, d1v, d1rd, wbv, wbt;
    int e_cnt, e_full, e_v0, e_rd0, e_v1, e_rd1;
  } vec_t;
  vec_t tbl [14];

  task automatic chk_out(input string nm, input int e_cnt, input int e_full,
                         input int e_v0, input int e_rd0, input int e_v1, input int e_rd1);
    chk({nm, "_cnt"}, 64'(cnt), 64'(e_cnt));
    chk({nm, "_full"}, 64'(full), 64'(e_full));
    chk({nm, "_v0"}, 64'(v0), 64'(e_v0));
    chk({nm, "_v1"}, 64'(v1), 64'(e_v1));
    if (e_v0 != 0) chk({nm, "_rd0"}, 64'(u0.p_rd), 64'(e_rd0));
    if (e_v1 != 0) chk({nm, "_rd1"}, 64'(u1.p_rd), 64'(e_rd1));
  endtask

  initial begin
    //            d0v d0c rd rs1 rs2 r1 r2 d1v d1rd wbv wbt cnt full v0 rd0 v1 rd1
    tbl[0]  = '{1, 1, 10, 1, 1, 1, 1, 1, 11, 0, 0,  2, 0, 0, 0,  0, 0};
    tbl[1]  = '{0, 1, 0,  1, 1, 1, 1, 0, 0,  0, 0,  0, 0, 1, 10, 1, 11};
    tbl[2]  = '{0, 1, 0,  1, 1, 1, 1, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0};
    tbl[3]  = '{1, 1, 12, 20, 1, 0, 1, 1, 13, 0, 0,  2, 0, 0, 0,  0, 0};
    tbl[4]  = '{0, 1, 0,  1, 1, 1, 1, 0, 0,  0, 0,  1, 0, 1, 13, 0, 0};
`ifdef IQ_WAKEUP_BYPASS_EN
    tbl[5]  = '{0, 1, 0,  1, 1, 1, 1, 0, 0,  1, 20, 0, 0, 1, 12, 0, 0};
    tbl[6]  = '{0, 1, 0,  1, 1, 1, 1, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0};
`else
    tbl[5]  = '{0, 1, 0,  1, 1, 1, 1, 0, 0,  1, 20, 1, 0, 0, 0,  0, 0};
    tbl[6]  = '{0, 1, 0,  1, 1, 1, 1, 0, 0,  0, 0,  0, 0, 1, 12, 0, 0};
`endif
    tbl[7]  = '{1, 1, 14, 1, 30, 1, 0, 0, 0,  1, 30, 1, 0, 0, 0,  0, 0};
    tbl[8]  = '{0, 1, 0,  1, 1, 1, 1, 0, 0,  0, 0,  0, 0, 1, 14, 0, 0};
    tbl[9]  = '{1, 0, 15, 1, 1, 1, 1, 1, 16, 0, 0,  1, 0, 0, 0,  0, 0};
    tbl[10] = '{0, 1, 0,  1, 1, 1, 1, 0, 0,  0, 0,  0, 0, 1, 16, 0, 0};
    tbl[11] = '{0, 1, 0,  1, 1, 1, 1, 1, 17, 0, 0,  1, 0, 0, 0,  0, 0};
    tbl[12] = '{0, 1, 0,  1, 1, 1, 1, 0, 0,  0, 0,  0, 0, 1, 17, 0, 0};
    tbl[13] = '{0, 1, 0,  1, 1, 1, 1, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0};

    clear_in();
    rst_n = 1'b0;
    step();
    step();
    chk_out("reset", 0, 0, 0, 0, 0, 0);
    chk("reset_u0", 64'(u0), 64'd0);
    chk("reset_u1", 64'(u1), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_out($sformatf("idle%0d", i), 0, 0, 0, 0, 0, 0);
    end

    for (int i = 0; i < 14; i++) begin
      clear_in();
      d0v  = 1'(tbl[i].d0v);
      d0u  = mk(6'(tbl[i].d0rd), 6'(tbl[i].d0rs1), 6'(tbl[i].d0rs2), 1'(tbl[i].d0c));
      d0r1 = 1'(tbl[i].d0r1);
      d0r2 = 1'(tbl[i].d0r2);
      d1v  = 1'(tbl[i].d1v);
      d1u  = mk(6'(tbl[i].d1rd), 6'd1, 6'd1, 1'b1);
      d1r1 = 1'b1;
      d1r2 = 1'b1;
      wb0v = 1'(tbl[i].wbv);
      wb0t = 6'(tbl[i].wbt);
      step();
      chk_out($sformatf("tbl%0d", i), tbl[i].e_cnt, tbl[i].e_full, tbl[i].e_v0,
              tbl[i].e_rd0, tbl[i].e_v1, tbl[i].e_rd1);
    end

    // Fill with uops waiting on tag 40 until the queue reports full
    for (int i = 0; i < 3; i++) begin
      clear_in();
      d0v = 1'b1; d0u = mk(6'(20 + 2 * i), 6'd40, 6'd1, 1'b1); d0r2 = 1'b1;
      d1v = 1'b1; d1u = mk(6'(21 + 2 * i), 6'd40, 6'd1, 1'b1); d1r2 = 1'b1;
      step();
      chk_out($sformatf("fill%0d", i), 2 * i + 2, 0, 0, 0, 0, 0);
    end
    clear_in();
    d0v = 1'b1; d0u = mk(6'd26, 6'd40, 6'd1, 1'b1); d0r2 = 1'b1;
    step();
    chk_out("fill_last", 7, 1, 0, 0, 0, 0);
    clear_in();
    d0v = 1'b1; d0u = mk(6'd27, 6'd1, 6'd1, 1'b1); d0r1 = 1'b1; d0r2 = 1'b1;
    d1v = 1'b1; d1u = mk(6'd28, 6'd1, 6'd1, 1'b1); d1r1 = 1'b1; d1r2 = 1'b1;
    step();
    chk_out("drop", 7, 1, 0, 0, 0, 0);
    clear_in();
    wb0v = 1'b1; wb0t = 6'd40;
    step();
    clear_in();
    for (int i = 0; i < 6; i++) step();
    chk_out("drain", 0, 0, 0, 0, 0, 0);

    // Stall holds the issued pair while dispatch continues underneath
    clear_in();
    d0v = 1'b1; d0u = mk(6'd1, 6'd1, 6'd1, 1'b1); d0r1 = 1'b1; d0r2 = 1'b1;
    d1v = 1'b1; d1u = mk(6'd2, 6'd1, 6'd1, 1'b1); d1r1 = 1'b1; d1r2 = 1'b1;
    step();
    chk_out("st_a", 2, 0, 0, 0, 0, 0);
    d0u = mk(6'd3, 6'd1, 6'd1, 1'b1);
    d1u = mk(6'd4, 6'd1, 6'd1, 1'b1);
    step();
    chk_out("st_b", 2, 0, 1, 1, 1, 2);
    for (int i = 0; i < 3; i++) begin
      clear_in();
      stall = 1'b1;
      if (i == 0) begin
        d0v = 1'b1; d0u = mk(6'd5, 6'd1, 6'd1, 1'b1); d0r1 = 1'b1; d0r2 = 1'b1;
      end
      step();
      chk_out($sformatf("st_hold%0d", i), 3, 0, 1, 1, 1, 2);
    end
    clear_in();
    step();
    chk_out("st_rel", 1, 0, 1, 3, 1, 4);
    step();
    chk_out("st_tail", 0, 0, 1, 5, 0, 0);

    // Random traffic with occasional mid-run resets
    clear_in();
    rst_n = 1'b0;
    step();
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      d0v   = ($urandom_range(0, 3) != 0);
      d1v   = ($urandom_range(0, 3) != 0);
      d0u   = rnd_uop();
      d1u   = rnd_uop();
      d0r1  = 1'($urandom_range(0, 1));
      d0r2  = 1'($urandom_range(0, 1));
      d1r1  = 1'($urandom_range(0, 1));
      d1r2  = 1'($urandom_range(0, 1));
      wb0v  = ($urandom_range(0, 9) < 4);
      wb1v  = ($urandom_range(0, 9) < 3);
      wb0t  = 6'($urandom_range(0, 7));
      wb1t  = 6'($urandom_range(0, 7));
      stall = ($urandom_range(0, 4) == 0);
      step();
      chk($sformatf("rnd%0d_cnt", c), 64'(cnt), 64'(mq.size()));
      chk($sformatf("rnd%0d_full", c), 64'(full), 64'(m_full));
      chk($sformatf("rnd%0d_v0", c), 64'(v0), 64'(m_v0));
      chk($sformatf("rnd%0d_v1", c), 64'(v1), 64'(m_v1));
      if (m_v0) chk($sformatf("rnd%0d_u0", c), 64'(u0), 64'(m_u0));
      if (m_v1) chk($sformatf("rnd%0d_u1", c), 64'(u1), 64'(m_u1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
